// File: rtl/match_report_sequencer.sv
// Queues SAD match coordinates and serializes each one as a 5-byte packet to a UART TX byte port.
// A frame that ends with no match produces a sentinel packet (x=0x3FF, y=0x1FF).
module match_report_sequencer #(
  parameter int unsigned FifoDepth = 4,
  parameter logic [7:0]  Header    = 8'hA5
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       match_valid_i,
  input  logic [9:0] match_x_i,
  input  logic [8:0] match_y_i,
  input  logic       frame_done_i,
  input  logic       tx_ready_i,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  output logic       send_complete_o,
  output logic       fifo_full_o,
  output logic       overflow_o,
  output logic       busy_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StDone} state_e;

  state_e          state_q, state_d;
  logic [18:0]     mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [9:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;
  logic [2:0]      idx_q, idx_d;
  logic            pending_miss_q, pending_miss_d;
  logic            saw_match_q, saw_match_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            send_complete_q, send_complete_d;
  logic            fifo_full_q, fifo_full_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;

  logic full, push, pop, consume_miss;

  function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [9:0] x,
                                          input logic [8:0] y);
    logic [7:0] b;
    case (idx)
      3'd1:    b = {6'b0, x[9:8]};
      3'd2:    b = x[7:0];
      3'd3:    b = {7'b0, y[8]};
      3'd4:    b = y[7:0];
      default: b = Header;
    endcase
    return b;
  endfunction

  // A pop only happens from IDLE, so a full FIFO accepts a push only in that cycle.
  assign full = (count_q == CntW'(FifoDepth));
  assign pop  = (state_q == StIdle) && (count_q != '0);
  assign push = match_valid_i && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    x_d             = x_q;
    y_d             = y_q;
    tx_valid_d      = tx_valid_q;
    tx_data_d       = tx_data_q;
    send_complete_d = 1'b0;
    consume_miss    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          {x_d, y_d} = mem_q[rd_ptr_q];
          state_d    = StLoad;
        end else if (pending_miss_q) begin
          x_d          = 10'h3FF;
          y_d          = 9'h1FF;
          consume_miss = 1'b1;
          state_d      = StLoad;
        end
      end
      StLoad: begin
        idx_d      = 3'd0;
        tx_data_d  = Header;
        tx_valid_d = 1'b1;
        state_d    = StSend;
      end
      StSend: begin
        if (tx_valid_q && tx_ready_i) begin
          if (idx_q < 3'd4) begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = pkt_byte(idx_q + 3'd1, x_q, y_q);
          end else begin
            tx_valid_d      = 1'b0;
            send_complete_d = 1'b1;
            state_d         = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A coincident match suppresses the miss; a new miss may re-arm in the cycle one is consumed.
  always_comb begin
    pending_miss_d = pending_miss_q;
    if (consume_miss) pending_miss_d = 1'b0;
    if (frame_done_i && !saw_match_q && !match_valid_i) pending_miss_d = 1'b1;
    saw_match_d = saw_match_q;
    if (match_valid_i) saw_match_d = 1'b1;
    if (frame_done_i)  saw_match_d = 1'b0;
    fifo_full_d = (count_d == CntW'(FifoDepth));
    overflow_d  = overflow_q || (match_valid_i && full && !pop);
    busy_d      = (state_d != StIdle) || (count_d != '0) || pending_miss_d;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      x_q             <= '0;
      y_q             <= '0;
      idx_q           <= '0;
      pending_miss_q  <= 1'b0;
      saw_match_q     <= 1'b0;
      tx_valid_q      <= 1'b0;
      tx_data_q       <= '0;
      send_complete_q <= 1'b0;
      fifo_full_q     <= 1'b0;
      overflow_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      x_q             <= x_d;
      y_q             <= y_d;
      idx_q           <= idx_d;
      pending_miss_q  <= pending_miss_d;
      saw_match_q     <= saw_match_d;
      tx_valid_q      <= tx_valid_d;
      tx_data_q       <= tx_data_d;
      send_complete_q <= send_complete_d;
      fifo_full_q     <= fifo_full_d;
      overflow_q      <= overflow_d;
      busy_q          <= busy_d;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {match_x_i, match_y_i};
    end
  end

  assign tx_valid_o      = tx_valid_q;
  assign tx_data_o       = tx_data_q;
  assign send_complete_o = send_complete_q;
  assign fifo_full_o     = fifo_full_q;
  assign overflow_o      = overflow_q;
  assign busy_o          = busy_q;

endmodule

// File: tb/tb_match_report_sequencer.sv
// Scoreboard bench: stimulus queues expected bytes, a negedge monitor checks every accepted byte.
module tb_match_report_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       match_valid;
  logic [9:0] match_x;
  logic [8:0] match_y;
  logic       frame_done;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       send_complete;
  logic       fifo_full;
  logic       overflow;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  int exp_done  = 0;
  logic [7:0] exp_q [$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_sc    = 1'b0;
  logic [7:0] exp_b;

  match_report_sequencer dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .match_valid_i  (match_valid),
    .match_x_i      (match_x),
    .match_y_i      (match_y),
    .frame_done_i   (frame_done),
    .tx_ready_i     (tx_ready),
    .tx_valid_o     (tx_valid),
    .tx_data_o      (tx_data),
    .send_complete_o(send_complete),
    .fifo_full_o    (fifo_full),
    .overflow_o     (overflow),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [9:0] x, input logic [8:0] y);
    exp_q.push_back(8'hA5);
    exp_q.push_back({6'b0, x[9:8]});
    exp_q.push_back(x[7:0]);
    exp_q.push_back({7'b0, y[8]});
    exp_q.push_back(y[7:0]);
    exp_done++;
  endtask

  task automatic send_match(input logic [9:0] x, input logic [8:0] y);
    match_valid = 1'b1;
    match_x     = x;
    match_y     = y;
    push_pkt(x, y);
    tick();
    match_valid = 1'b0;
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check({name, "_in_time"}, 32'(n < 300), 32'd1);
    check({name, "_completes"}, done_seen, exp_done);
  endtask

  // Monitor: checks accepted bytes, hold-while-stalled and single-cycle completion pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_sc    = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(tx_valid), 32'd1);
        check("stall_data_held", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(exp_b));
        end
      end
      if (send_complete) begin
        done_seen++;
        check("send_complete_width", 32'(prev_sc), 32'd0);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_sc    = send_complete;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] rdy_pat;
    rst = 1'b1;
    match_valid = 1'b0;
    match_x = '0;
    match_y = '0;
    frame_done = 1'b0;
    tx_ready = 1'b1;
    tick();
    tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_outputs", {28'd0, send_complete, fifo_full, overflow, busy}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Single match: header appears two edges after the strobe, then 5 back-to-back bytes.
    send_match(10'h2A5, 9'h13C);
    check("lat_edge_n", 32'(tx_valid), 32'd0);
    tick();
    check("lat_edge_n1", 32'(tx_valid), 32'd0);
    tick();
    check("lat_hdr_valid", 32'(tx_valid), 32'd1);
    check("lat_hdr_data", 32'(tx_data), 32'hA5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("consecutive_valid", 32'(tx_valid), 32'd1);
    end
    check("sc_not_early", 32'(send_complete), 32'd0);
    tick();
    check("sc_after_last", 32'(send_complete), 32'd1);
    check("valid_drop_after_last", 32'(tx_valid), 32'd0);
    wait_idle("single");

    // frame_done right after a match frame: no miss packet.
    pulse_frame_done();
    for (int i = 0; i < 4; i++) tick();
    check("no_miss_after_match", 32'(busy), 32'd0);

    // Two empty frames: two miss packets.
    pulse_frame_done();
    push_pkt(10'h3FF, 9'h1FF);
    wait_idle("miss1");
    pulse_frame_done();
    push_pkt(10'h3FF, 9'h1FF);
    wait_idle("miss2");

    // Six strobes while stalled: one in shadow, four queued, sixth dropped.
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      match_valid = 1'b1;
      match_x = 10'(10'h100 + i * 10'h41);
      match_y = 9'(9'h0F0 + i * 9'h23);
      if (i < 5) push_pkt(match_x, match_y);
      tick();
    end
    match_valid = 1'b0;
    check("ovf_fifo_full", 32'(fifo_full), 32'd1);
    check("ovf_overflow", 32'(overflow), 32'd1);
    tick();
    check("ovf_stall_no_accept", 32'(exp_q.size()), 32'd25);
    tx_ready = 1'b1;
    wait_idle("overflow_drain");
    check("ovf_full_cleared", 32'(fifo_full), 32'd0);

    // Ready toggling 1,0,0,1 mid-packet.
    send_match(10'h1C3, 9'h0A7);
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    check("toggle_hdr_seen", 32'(tx_valid), 32'd1);
    rdy_pat = 4'b1001;
    for (int i = 3; i >= 0; i--) begin
      tx_ready = rdy_pat[i];
      tick();
    end
    tx_ready = 1'b1;
    wait_idle("toggle");

    // Coincident frame_done and match: match packet only.
    match_valid = 1'b1;
    frame_done  = 1'b1;
    match_x = 10'd5;
    match_y = 9'd7;
    push_pkt(10'd5, 9'd7);
    tick();
    match_valid = 1'b0;
    frame_done  = 1'b0;
    wait_idle("coincident");
    for (int i = 0; i < 6; i++) tick();
    check("coincident_no_miss", 32'(busy), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset while byte 2 is presented.
    send_match(10'h155, 9'h0AA);
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("rst_mid_byte2", 32'(tx_data), 32'h55);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(tx_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    exp_done--;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("rst_no_complete", done_seen, exp_done);
    send_match(10'h07E, 9'h101);
    wait_idle("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/match_report_sequencer.md
Name: match_report_sequencer

Overview:
- Buffers SAD match coordinates from the processing element and control unit, and serializes each as a 5-byte packet to the UART transmitter.
- Sends a "no match" packet (x=0x3FF, y=0x1FF) when a frame finishes with no match.
- Pulses send_complete after each packet so the control unit can resume searching.
- Sits between the top-level output handling and the UART TX byte interface.

Parameters:
- FIFO_DEPTH, 4, number of coordinate entries buffered (power of two, ≥2)
- HEADER, 8'hA5, first byte of every packet

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- match_valid  in  1  one-cycle strobe; match_x/match_y valid
- match_x  in  10  match column
- match_y  in  9  match row
- frame_done  in  1  one-cycle strobe; search of current frame finished
- tx_ready  in  1  UART TX can accept a byte
- tx_valid  out  1  tx_data valid; held until accepted
- tx_data  out  8  byte to transmit
- send_complete  out  1  one-cycle pulse after the last byte of a packet is accepted
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky; a match was dropped
- busy  out  1  high when FSM not IDLE or FIFO non-empty or miss pending

Behaviour:
- Reset values: tx_valid=0, tx_data=0, send_complete=0, fifo_full=0, overflow=0, busy=0. FIFO empty, pending_miss=0, saw_match=0, FSM=IDLE.
- All outputs are registered.
- Byte transfer: a byte is accepted on a rising edge where tx_valid=1 and tx_ready=1. tx_data is stable while tx_valid=1 and not accepted.
- Packet, byte order 0..4: HEADER, {6'b0,x[9:8]}, x[7:0], {7'b0,y[8]}, y[7:0].
- FIFO push: on match_valid. If full and no pop in the same cycle, the entry is dropped and overflow is set; overflow clears only on reset. If full and a pop occurs in the same cycle, the push is accepted and the count is unchanged.
- saw_match is set on any match_valid, including a dropped one.
- On frame_done: if saw_match=0 and match_valid=0 in that cycle, set pending_miss. Always clear saw_match. If frame_done and match_valid coincide, the match counts and no miss is raised.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - If FIFO non-empty: pop head into the x/y shadow registers, go to LOAD.
  - Else if pending_miss: load x=0x3FF, y=0x1FF, clear pending_miss, go to LOAD.
  - FIFO entries have priority over the miss packet.
- LOAD: idx=0, tx_data=HEADER, tx_valid=1, go to SEND.
- SEND: on acceptance, if idx<4 then idx++, present the next byte, and keep tx_valid=1 (back-to-back bytes allowed). If idx=4, set tx_valid=0 and go to DONE.
- DONE: send_complete=1 for exactly one cycle, return to IDLE.
- Latency: match_valid at edge N with the FIFO empty and FSM in IDLE → tx_valid=1 with HEADER after edge N+2. Minimum packet time is 5 accepted bytes plus 3 cycles of overhead.
- tx_ready low stalls SEND indefinitely with no byte loss. Incoming matches continue to queue during the stall.
- Reset mid-packet: the partial packet is abandoned, tx_valid drops immediately, and the FIFO and flags clear. No send_complete is issued.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.

Test Plan:
- Single match x=0x2A5, y=0x13C, tx_ready=1 → bytes A5,02,A5,01,3C on 5 consecutive cycles starting 2 cycles after the strobe; send_complete pulses once, the cycle after byte 4 is accepted.
- frame_done with no prior match → packet A5,03,FF,01,FF, then send_complete; a second frame_done with no match → second identical packet.
- 6 matches on back-to-back cycles with tx_ready=0 and FIFO_DEPTH=4 → first match popped to the shadow register, next 4 queued, 6th dropped; overflow=1. After tx_ready=1, exactly 5 packets are sent in arrival order.
- tx_ready toggling 1,0,0,1 during a packet → tx_data holds during low cycles; no byte duplicated or skipped; send_complete fires once.
- frame_done and match_valid in the same cycle (x=5, y=7) → only packet A5,00,05,00,07; no miss packet.
- reset asserted during byte 2 → tx_valid=0 asynchronously, busy=0, overflow=0. A new match after reset produces a complete packet starting with HEADER.
